// File: rtl/mem_fetch_ncl_encoder.sv
// rtl/mem_fetch_ncl_encoder.sv - clocked program-memory fetch sequencer driving dual-rail NCL wavefronts
//
// Purpose:
//   Fetches bytes from a synchronous single-rail program memory. Each byte is
//   re-encoded as a dual-rail NCL DATA wavefront with a PH0 phase rail:
//   PH0 true marks an instruction byte and PH0 false marks a constant byte.
//   The wavefront is returned to NULL under the downstream completion handshake.
//   The block owns the program counter and the instruction/constant sequencing.
//
// Ports:
//   clk, rst          single clock (rising edge), asynchronous active-high reset
//   run               1 = keep fetching, 0 = stop at the next NULL boundary
//   jmp_en, jmp_addr  PC load request and target, honoured in NULL only
//   mem_addr, mem_rd  memory read address and strobe (data valid one cycle later)
//   mem_rdata         memory read data
//   ack_in            downstream completion: 1 = DATA consumed, 0 = NULL consumed
//   PH0_t, PH0_f      phase rail pair
//   D_t, D_f          data rail pairs, bit i maps to Di_t / Di_f
//   pc                current program counter (debug)
//   err               handshake timeout flag
//
// Configuration:
//   FETCH_ACK_TIMEOUT_EN  when defined, a wait counter flags err after TIMEOUT
//                         cycles without an ack edge and locks the block in
//                         IDLE until reset; when undefined err is tied to 0.

module mem_fetch_ncl_encoder #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int                CONST_BIT = 7,
   parameter int                TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              jmp_en,
   input  logic [ADDR_W-1:0] jmp_addr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   input  logic              ack_in,
   output logic              PH0_t,
   output logic              PH0_f,
   output logic [7:0]        D_t,
   output logic [7:0]        D_f,
   output logic [ADDR_W-1:0] pc,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DATA,
      S_NULL
   } state_t;

   state_t state;
   logic   phase;       // 1 = the byte being fetched is an instruction
   logic   const_flag;  // CONST_BIT of the byte currently on the rails
   logic   locked;      // set once a handshake timeout has been flagged

`ifdef FETCH_ACK_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // The counter holds the number of completed wait cycles, so the flag
   // fires on the edge that ends the TIMEOUT-th cycle spent waiting.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_r;
   logic             timeout_hit;

   assign timeout_hit = (wait_cnt == CNT_LAST);
   assign locked      = err_r;
   assign err         = err_r;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign locked         = 1'b0;
   assign err            = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         phase      <= 1'b1;
         const_flag <= 1'b0;
         pc         <= RESET_PC;
         mem_addr   <= RESET_PC;
         mem_rd     <= 1'b0;
         PH0_t      <= 1'b0;
         PH0_f      <= 1'b0;
         D_t        <= 8'h00;
         D_f        <= 8'h00;
`ifdef FETCH_ACK_TIMEOUT_EN
         wait_cnt   <= '0;
         err_r      <= 1'b0;
`endif
      end else begin
         // The strobe is a single-cycle pulse raised only on entry to FETCH.
         mem_rd <= 1'b0;

         case (state)
            S_IDLE: begin
               if (run && !ack_in && !locked) begin
                  state    <= S_FETCH;
                  mem_rd   <= 1'b1;
                  mem_addr <= pc;
               end
            end

            S_FETCH: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               // Memory data is valid here; all nine rail pairs launch together.
               const_flag <= mem_rdata[CONST_BIT];
               D_t        <= mem_rdata;
               D_f        <= ~mem_rdata;
               PH0_t      <= phase;
               PH0_f      <= ~phase;
               state      <= S_DATA;
`ifdef FETCH_ACK_TIMEOUT_EN
               wait_cnt   <= '0;
`endif
            end

            S_DATA: begin
               if (ack_in) begin
                  D_t   <= 8'h00;
                  D_f   <= 8'h00;
                  PH0_t <= 1'b0;
                  PH0_f <= 1'b0;
                  pc    <= pc + ADDR_W'(1);
                  // Only a flagged instruction is followed by a constant;
                  // a constant always hands back to an instruction.
                  phase <= phase ? ~const_flag : 1'b1;
                  state <= S_NULL;
`ifdef FETCH_ACK_TIMEOUT_EN
                  wait_cnt <= '0;
               end else if (timeout_hit) begin
                  err_r <= 1'b1;
                  D_t   <= 8'h00;
                  D_f   <= 8'h00;
                  PH0_t <= 1'b0;
                  PH0_f <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
`endif
               end
            end

            S_NULL: begin
               // A jump replaces the increment taken on the DATA->NULL edge.
               if (jmp_en) begin
                  pc    <= jmp_addr;
                  phase <= 1'b1;
               end
               if (!ack_in) begin
                  if (run) begin
                     state    <= S_FETCH;
                     mem_rd   <= 1'b1;
                     mem_addr <= jmp_en ? jmp_addr : pc;
                  end else begin
                     state <= S_IDLE;
                  end
`ifdef FETCH_ACK_TIMEOUT_EN
               end else if (timeout_hit) begin
                  err_r <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
`endif
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_fetch_ncl_encoder.sv
// tb/tb_mem_fetch_ncl_encoder.sv - scoreboard bench for mem_fetch_ncl_encoder

module tb_mem_fetch_ncl_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       jmp_en;
   logic [7:0] jmp_addr;
   logic [7:0] mem_addr;
   logic       mem_rd;
   logic [7:0] mem_rdata;
   logic       ack_in;
   logic       PH0_t, PH0_f;
   logic [7:0] D_t, D_f;
   logic [7:0] pc;
   logic       err;

   int total = 0;
   int bad   = 0;
   int rd_count = 0;
   int viol = 0;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic       ph;
   } exp_t;

   exp_t exp_q[$];
   logic [7:0] mem [256];
   logic prev_data = 1'b0;

   always #5 clk = ~clk;

   mem_fetch_ncl_encoder #(
      .ADDR_W   (8),
      .RESET_PC (8'h00),
      .CONST_BIT(7),
      .TIMEOUT  (255)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .jmp_en   (jmp_en),
      .jmp_addr (jmp_addr),
      .mem_addr (mem_addr),
      .mem_rd   (mem_rd),
      .mem_rdata(mem_rdata),
      .ack_in   (ack_in),
      .PH0_t    (PH0_t),
      .PH0_f    (PH0_f),
      .D_t      (D_t),
      .D_f      (D_f),
      .pc       (pc),
      .err      (err)
   );

   // Synchronous program memory: data valid one cycle after the strobe.
   always @(posedge clk) begin
      if (mem_rd) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Monitor: address check on each strobe, wavefront check on each DATA launch.
   always @(negedge clk) begin
      exp_t e;
      logic cur;
      cur = PH0_t | PH0_f;
      if ((D_t & D_f) != 8'h00 || (PH0_t & PH0_f)) viol++;
      if (!rst) begin
         if (mem_rd === 1'b1) begin
            rd_count++;
            if (exp_q.size() == 0) chk("unexpected_mem_rd", 32'(mem_addr), 32'hFFFF_FFFF);
            else chk("mem_addr", 32'(mem_addr), 32'(exp_q[0].addr));
         end
         if (cur && !prev_data) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_data", 32'({PH0_t, PH0_f, D_t, D_f}), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("wavefront@%02h", e.addr), 32'({PH0_t, PH0_f, D_t, D_f}),
                   32'({e.ph, ~e.ph, e.data, ~e.data}));
            end
         end
      end
      prev_data = cur;
   end

   // Issue one byte: queue its expectation, wait for DATA, hold ack off for
   // dly cycles, acknowledge, then release to NULL with optional jump/stop.
   task automatic serve(input logic [7:0] a, input logic [7:0] d, input logic ph,
                        input int dly, input logic do_jmp, input logic [7:0] ja,
                        input logic last);
      exp_t e;
      int n;
      int hold_bad;
      logic [7:0] np;
      e.addr = a; e.data = d; e.ph = ph;
      exp_q.push_back(e);
      @(negedge clk);
      jmp_en = 1'b0;
      n = 0;
      while (!(PH0_t | PH0_f) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!(PH0_t | PH0_f)) begin
         chk($sformatf("data_timeout@%02h", a), 32'd0, 32'd1);
         return;
      end
      hold_bad = 0;
      repeat (dly) begin
         @(negedge clk);
         if (D_t !== d || D_f !== ~d || mem_rd !== 1'b0) hold_bad++;
      end
      chk($sformatf("hold_stable@%02h", a), 32'(hold_bad), 32'd0);
      ack_in = 1'b1;
      n = 0;
      @(negedge clk);
      while ((PH0_t | PH0_f) && n < 5) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("null_rails@%02h", a), 32'({PH0_t, PH0_f, D_t, D_f}), 32'h0);
      np = a + 8'd1;
      chk($sformatf("pc_incr@%02h", a), 32'(pc), 32'(np));
      if (do_jmp) begin
         jmp_en   = 1'b1;
         jmp_addr = ja;
      end
      if (last) run = 1'b0;
      ack_in = 1'b0;
   endtask

   initial begin
      int n;
      exp_t e;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h15;
      mem[8'h01] = 8'h83;
      mem[8'h02] = 8'h42;
      mem[8'h03] = 8'h80;
      mem[8'h40] = 8'h91;
      mem[8'h41] = 8'h07;
      mem[8'hFF] = 8'h3C;

      rst = 1'b1; run = 1'b0; ack_in = 1'b0; jmp_en = 1'b0; jmp_addr = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset_rails", 32'({PH0_t, PH0_f, D_t, D_f}), 32'h0);
      chk("reset_pc", 32'(pc), 32'h00);
      chk("reset_err", 32'(err), 32'h0);
      chk("reset_mem_rd", 32'(mem_rd), 32'h0);
      chk("reset_mem_addr", 32'(mem_addr), 32'h00);
      rst = 1'b0;
      run = 1'b1;

      serve(8'h00, 8'h15, 1'b1, 2,  1'b0, 8'h00, 1'b0);
      serve(8'h01, 8'h83, 1'b1, 2,  1'b0, 8'h00, 1'b0);
      serve(8'h02, 8'h42, 1'b0, 1,  1'b0, 8'h00, 1'b0);
      serve(8'h03, 8'h80, 1'b1, 50, 1'b1, 8'h40, 1'b0);
      serve(8'h40, 8'h91, 1'b1, 0,  1'b0, 8'h00, 1'b0);
      serve(8'h41, 8'h07, 1'b0, 3,  1'b1, 8'hFF, 1'b0);
      serve(8'hFF, 8'h3C, 1'b1, 1,  1'b0, 8'h00, 1'b0);
      serve(8'h00, 8'h15, 1'b1, 2,  1'b0, 8'h00, 1'b1);
      @(negedge clk);
      jmp_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("stopped_rd_count", 32'(rd_count), 32'd8);
      chk("stopped_rails", 32'({PH0_t, PH0_f, D_t, D_f}), 32'h0);

      // Asynchronous reset in the middle of a DATA wavefront.
      e.addr = 8'h01; e.data = 8'h83; e.ph = 1'b1;
      exp_q.push_back(e);
      run = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(PH0_t | PH0_f) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("midreset_data_seen", 32'(PH0_t | PH0_f), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("midreset_rails", 32'({PH0_t, PH0_f, D_t, D_f}), 32'h0);
      chk("midreset_pc", 32'(pc), 32'h00);
      chk("midreset_err", 32'(err), 32'h0);
      run = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("rail_pair_exclusive", 32'(viol), 32'd0);
      chk("final_rd_count", 32'(rd_count), 32'd9);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_fetch_ncl_encoder.md
Name: mem_fetch_ncl_encoder

Overview:
Clocked fetch sequencer that sits directly upstream of the NCL memory-data demux.
- Reads bytes from a synchronous single-rail program memory.
- Re-encodes each byte as a dual-rail NCL DATA wavefront, tagged with the PH0 phase rail (PH0 true = instruction byte, PH0 false = constant byte).
- Drives these onto the D7..D0 / PH0 rails, then returns them to NULL under the downstream completion handshake.
- Owns the program counter and the instruction/constant phase sequencing.

Parameters:
ADDR_W, 8, program counter and memory address width in bits.
RESET_PC, 0, PC value loaded on reset.
CONST_BIT, 7, bit of an instruction byte that, when 1, means the next byte is a constant.
TIMEOUT, 255, cycles to wait for an acknowledge edge before flagging an error (optional feature only).

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
run  in  1  1 = keep fetching; 0 = stop at the next NULL boundary.
jmp_en  in  1  load PC from jmp_addr (taken in NULL state only).
jmp_addr  in  ADDR_W  jump target.
mem_addr  out  ADDR_W  memory read address.
mem_rd  out  1  memory read strobe; data is valid exactly 1 cycle later.
mem_rdata  in  8  memory read data.
ack_in  in  1  downstream completion: 1 = DATA consumed, 0 = NULL consumed.
PH0_t, PH0_f  out  1 each  phase dual-rail.
D_t, D_f  out  8 each  data dual-rail; bit i maps to Di_t / Di_f.
pc  out  ADDR_W  current PC (debug).
err  out  1  handshake timeout flag.

Behaviour:
Interface rules (decided): one clock, clk; reset rst is asynchronous and active-high.

Reset values (async, while rst=1):
- State IDLE; all rails 0 (NULL); mem_rd=0; mem_addr=RESET_PC; pc=RESET_PC; phase=instruction; err=0.
- Reset asserted mid-operation forces NULL immediately, whatever the current wavefront.

Outputs:
- All outputs are registered; no combinational path from inputs to the rails.

State machine:
- IDLE: rails NULL. If run=1 and ack_in=0 → FETCH.
- FETCH (1 cycle): mem_rd=1, mem_addr=pc → WAIT.
- WAIT (1 cycle): capture mem_rdata into the byte register → DATA.
- DATA:
  - For each bit: D_t[i]=byte[i], D_f[i]=~byte[i].
  - PH0_t=phase, PH0_f=~phase.
  - All 9 rail pairs assert on the same edge and hold stable until leaving DATA.
  - On ack_in=1 → NULL, and on that same edge:
    - pc ← pc+1, wrapping modulo 2^ADDR_W (all-ones → 0).
    - Next phase: if the current byte is an instruction with byte[CONST_BIT]=1, next = constant; otherwise next = instruction. A constant byte is always followed by an instruction.
- NULL:
  - All 18 rails 0, deasserted on the same edge.
  - If jmp_en=1: pc ← jmp_addr and next phase forced to instruction; the jump overrides the increment already applied.
  - On ack_in=0: run=1 → FETCH, run=0 → IDLE.
  - The jump may be taken on the same cycle as the exit.

Handshake invariants:
- Never both rails of a pair high.
- Never a DATA→DATA or NULL→NULL transition without the matching ack_in edge.
- DATA is first driven at least 3 cycles after ack_in falls.
- ack_in is assumed to be synchronised externally.

Other rules:
- jmp_en is ignored outside NULL.
- mem_rd pulses exactly once per byte.

Optional Feature:
Macro: FETCH_ACK_TIMEOUT_EN
- Defined:
  - A counter clears on entering DATA or NULL and counts each cycle spent waiting there.
  - When it reaches TIMEOUT: err is set (sticky until rst), rails go NULL, state goes IDLE, and run is ignored until reset.
- Undefined: no counter is built, err is tied to 0, and the block waits indefinitely.

Test Plan:
1. Reset with rst=1 mid-DATA → all rails 0 within the same cycle, pc=0, err=0.
2. mem[0]=0x15, run=1, downstream acks after 2 cycles → PH0_t=1; D_t=0x15, D_f=0xEA; after ack_in=1 all rails are NULL; pc=1; next byte is again PH0_t=1.
3. mem[0]=0x83, mem[1]=0x42 → byte 0 goes out with PH0_t=1, byte 1 (0x42) with PH0_f=1; byte 2 returns to PH0_t=1.
4. ack_in held 0 for 50 cycles in DATA → rails hold 0x15 unchanged and mem_rd stays 0; release → exactly one NULL phase follows.
5. pc=0xFF at ADDR_W=8 with ack → pc=0x00. Separately: jmp_en=1, jmp_addr=0x40 in NULL after a constant-flagged instruction → next fetch reads address 0x40 with PH0_t=1.
6. With FETCH_ACK_TIMEOUT_EN and TIMEOUT=10, ack_in never rises → err=1 on the 10th cycle in DATA, rails NULL, no further mem_rd.
